// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and helpers for the cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned ADDR_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    TURN,
    FILL,
    DONE
  } adaptor_state_e;

  // Clears the byte-offset-within-line bits so memory only ever sees line-aligned addresses.
  function automatic logic [ADDR_MAX_W-1:0] line_align(input logic [ADDR_MAX_W-1:0] addr,
                                                        input int unsigned off);
    logic [ADDR_MAX_W-1:0] mask;
    mask = {ADDR_MAX_W{1'b1}} << off;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_beat_counter.sv
// Beat index shared by the write-back and fill phases; wraps after the last beat.
module beat_counter #(
  parameter int unsigned BEATS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       inc,
  output logic [$clog2(BEATS)-1:0]   cnt,
  output logic                       last
);

  localparam int unsigned CNT_W = $clog2(BEATS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Bridges whole-line cache requests onto a beat-wide burst memory port, including
// a combined victim write-back followed by a line fill under a single handshake.
module cacheline_burst_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [ADDR_W-1:0]  wb_address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF   = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W = $clog2(LINE_W);

  generate
    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || BEATS * BURST_W != LINE_W) begin : g_bad_cfg
      $error("cacheline_burst_adaptor: LINE_W/BURST_W must be a power of two >= 2");
    end
  endgenerate

  adaptor_state_e      state_q, state_d;
  logic [LINE_W-1:0]   buffer_q;
  logic [ADDR_W-1:0]   wb_addr_q, fill_addr_q;
  logic [ADDR_W-1:0]   fill_align, wb_align;
  logic                fill_pending_q;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_last, cnt_clear, cnt_inc, beat_done;
  logic [IDX_W-1:0]    beat_base;

  always_comb begin
    fill_align = ADDR_W'(line_align(ADDR_MAX_W'(address_i), OFF));
    wb_align   = ADDR_W'(line_align(ADDR_MAX_W'(wb_address_i), OFF));
  end

  assign cnt_inc   = resp_i && (state_q == WB || state_q == FILL);
  assign cnt_clear = (state_q == IDLE) || (state_q == TURN);
  assign beat_done = cnt_inc && cnt_last;
  assign beat_base = IDX_W'(int'(cnt) * BURST_W);

  beat_counter #(
    .BEATS(BEATS)
  ) u_beat_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .cnt    (cnt),
    .last   (cnt_last)
  );

  // State register: async reset drops the burst requests without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          state_d = WB;
        end else if (read_i) begin
          state_d = FILL;
        end
      end
      WB: begin
        write_o = 1'b1;
        if (beat_done) begin
          state_d = fill_pending_q ? TURN : DONE;
        end
      end
      TURN: begin
        state_d = FILL;
      end
      FILL: begin
        read_o = 1'b1;
        if (beat_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One line register serves as both victim source and fill destination; fill beats
  // only start landing after every victim beat has left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer_q       <= '0;
      wb_addr_q      <= '0;
      fill_addr_q    <= '0;
      fill_pending_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (write_i) begin
            buffer_q       <= line_i;
            wb_addr_q      <= read_i ? wb_align : fill_align;
            fill_pending_q <= read_i;
            if (read_i) begin
              fill_addr_q <= fill_align;
            end
          end else if (read_i) begin
            fill_addr_q    <= fill_align;
            fill_pending_q <= 1'b0;
          end
        end
        FILL: begin
          if (resp_i) begin
            buffer_q[beat_base +: BURST_W] <= burst_i;
          end
        end
        DONE: begin
          fill_pending_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign address_o = (state_q == WB) ? wb_addr_q : fill_addr_q;
  assign burst_o   = buffer_q[beat_base +: BURST_W];
  assign line_o    = buffer_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed scenario bench for cacheline_burst_adaptor (4-beat and 8-beat configurations).
module tb_cacheline_burst_adaptor;

  logic         clk;
  logic         reset_n;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, wb_address_i, address_o;
  logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;

  logic [255:0] line_i8, line_o8;
  logic [31:0]  address_i8, wb_address_i8, address_o8;
  logic         read_i8, write_i8, resp_o8, read_o8, write_o8, resp_i8;
  logic [31:0]  burst_i8, burst_o8;

  int n_tests;
  int n_fail;

  cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .wb_address_i(wb_address_i), .read_i(read_i),
    .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(32), .ADDR_W(32)) dut8 (
    .clk(clk), .reset_n(reset_n), .line_i(line_i8), .line_o(line_o8),
    .address_i(address_i8), .wb_address_i(wb_address_i8), .read_i(read_i8),
    .write_i(write_i8), .resp_o(resp_o8), .burst_i(burst_i8), .burst_o(burst_o8),
    .address_o(address_o8), .read_o(read_o8), .write_o(write_o8), .resp_i(resp_i8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++; if (read_o !== 1'b0)   begin n_fail++; $display("FAIL reset_read_o: got %b want 0", read_o); end
    n_tests++; if (write_o !== 1'b0)  begin n_fail++; $display("FAIL reset_write_o: got %b want 0", write_o); end
    n_tests++; if (resp_o !== 1'b0)   begin n_fail++; $display("FAIL reset_resp_o: got %b want 0", resp_o); end
    n_tests++; if (line_o !== '0)     begin n_fail++; $display("FAIL reset_line_o: got %h want 0", line_o); end
    n_tests++; if (burst_o !== '0)    begin n_fail++; $display("FAIL reset_burst_o: got %h want 0", burst_o); end
    n_tests++; if (address_o !== '0)  begin n_fail++; $display("FAIL reset_address_o: got %h want 0", address_o); end
    n_tests++; if (read_o8 !== 1'b0 || write_o8 !== 1'b0 || resp_o8 !== 1'b0)
      begin n_fail++; $display("FAIL reset_ctrl8: got %b%b%b want 000", read_o8, write_o8, resp_o8); end
  endtask

  task automatic test_read();
    logic [255:0] exp_line;
    int rd_cnt, resp_cnt, resp_cyc;
    for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = 64'hA0 + 64'(k);
    rd_cnt = 0; resp_cnt = 0; resp_cyc = 0;
    address_i = 32'h1234_5678; read_i = 1'b1; resp_i = 1'b1; burst_i = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      read_i = 1'b0;
      if (c == 1) begin
        n_tests++;
        if (address_o !== 32'h1234_5660) begin n_fail++; $display("FAIL read_addr: got %h want 12345660", address_o); end
      end
      if (read_o) rd_cnt++;
      if (resp_o) begin resp_cnt++; if (resp_cyc == 0) resp_cyc = c; end
      burst_i = (c <= 4) ? 64'hA0 + 64'(c - 1) : 64'h0;
    end
    n_tests++; if (rd_cnt !== 4)     begin n_fail++; $display("FAIL read_beats: got %0d want 4", rd_cnt); end
    n_tests++; if (resp_cyc !== 5)   begin n_fail++; $display("FAIL read_resp_cycle: got %0d want 5", resp_cyc); end
    n_tests++; if (resp_cnt !== 1)   begin n_fail++; $display("FAIL read_resp_count: got %0d want 1", resp_cnt); end
    n_tests++; if (line_o !== exp_line) begin n_fail++; $display("FAIL read_line: got %h want %h", line_o, exp_line); end
  endtask

  task automatic test_write_stall();
    logic [63:0] exp_b [6];
    int wr_cnt, resp_cyc;
    exp_b[0] = 64'hD0; exp_b[1] = 64'hD1; exp_b[2] = 64'hD2;
    exp_b[3] = 64'hD2; exp_b[4] = 64'hD2; exp_b[5] = 64'hD3;
    for (int k = 0; k < 4; k++) line_i[k*64 +: 64] = 64'hD0 + 64'(k);
    wr_cnt = 0; resp_cyc = 0;
    address_i = 32'h0000_0ABC; write_i = 1'b1; resp_i = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      write_i = 1'b0;
      if (c <= 6) begin
        n_tests++;
        if (burst_o !== exp_b[c-1] || address_o !== 32'h0000_0AA0) begin
          n_fail++;
          $display("FAIL write_beat%0d: got %h@%h want %h@00000aa0", c, burst_o, address_o, exp_b[c-1]);
        end
      end
      if (write_o) wr_cnt++;
      if (resp_o && resp_cyc == 0) resp_cyc = c;
      resp_i = (c == 3 || c == 4) ? 1'b0 : 1'b1;
    end
    n_tests++; if (wr_cnt !== 6)   begin n_fail++; $display("FAIL write_cycles: got %0d want 6", wr_cnt); end
    n_tests++; if (resp_cyc !== 7) begin n_fail++; $display("FAIL write_resp_cycle: got %0d want 7", resp_cyc); end
  endtask

  task automatic test_combined();
    logic [255:0] exp_line;
    int wr_cnt, rd_cnt, turn_cnt, resp_cyc, bad_wb;
    for (int k = 0; k < 4; k++) begin
      line_i[k*64 +: 64]   = 64'hB0 + 64'(k);
      exp_line[k*64 +: 64] = 64'hC0 + 64'(k);
    end
    wr_cnt = 0; rd_cnt = 0; turn_cnt = 0; resp_cyc = 0; bad_wb = 0;
    wb_address_i = 32'h100; address_i = 32'h200;
    write_i = 1'b1; read_i = 1'b1; resp_i = 1'b1; burst_i = '0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      write_i = 1'b0; read_i = 1'b0;
      if (write_o && address_o == 32'h100) wr_cnt++;
      if (read_o && address_o == 32'h200) rd_cnt++;
      if (c <= 9 && !read_o && !write_o) turn_cnt++;
      if (c <= 4 && burst_o !== 64'hB0 + 64'(c - 1)) bad_wb++;
      if (resp_o && resp_cyc == 0) resp_cyc = c;
      burst_i = (c >= 6 && c <= 9) ? 64'hC0 + 64'(c - 6) : 64'h0;
    end
    n_tests++; if (wr_cnt !== 4)    begin n_fail++; $display("FAIL comb_write_beats: got %0d want 4", wr_cnt); end
    n_tests++; if (bad_wb !== 0)    begin n_fail++; $display("FAIL comb_victim_data: got %0d bad want 0", bad_wb); end
    n_tests++; if (turn_cnt !== 1)  begin n_fail++; $display("FAIL comb_turn: got %0d want 1", turn_cnt); end
    n_tests++; if (rd_cnt !== 4)    begin n_fail++; $display("FAIL comb_read_beats: got %0d want 4", rd_cnt); end
    n_tests++; if (resp_cyc !== 10) begin n_fail++; $display("FAIL comb_resp_cycle: got %0d want 10", resp_cyc); end
    n_tests++; if (line_o !== exp_line) begin n_fail++; $display("FAIL comb_line: got %h want %h", line_o, exp_line); end
  endtask

  task automatic test_reset_mid_fill();
    logic [255:0] exp_line;
    int resp_cyc;
    address_i = 32'h0000_0040; read_i = 1'b1; resp_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      read_i = 1'b0;
      burst_i = 64'h77 + 64'(c);
    end
    n_tests++; if (read_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_read_o: got %b want 1", read_o); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: got %b want 0", read_o); end
    tick();
    n_tests++; if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0)
      begin n_fail++; $display("FAIL rst_idle: got %b%b%b want 000", resp_o, read_o, write_o); end
    n_tests++; if (line_o !== '0) begin n_fail++; $display("FAIL rst_line_clear: got %h want 0", line_o); end
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = 64'hE0 + 64'(k);
    resp_cyc = 0;
    address_i = 32'h0000_0040; read_i = 1'b1; resp_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      read_i = 1'b0;
      if (resp_o && resp_cyc == 0) resp_cyc = c;
      burst_i = (c <= 4) ? 64'hE0 + 64'(c - 1) : 64'h0;
    end
    n_tests++; if (resp_cyc !== 5) begin n_fail++; $display("FAIL rst_after_resp: got %0d want 5", resp_cyc); end
    n_tests++; if (line_o !== exp_line) begin n_fail++; $display("FAIL rst_after_line: got %h want %h", line_o, exp_line); end
  endtask

  task automatic test_beats8();
    logic [255:0] exp_line;
    int rd_cnt, resp_cyc;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = 32'h80 + 32'(r * 16) + 32'(k);
      rd_cnt = 0; resp_cyc = 0;
      address_i8 = 32'h0000_0047; read_i8 = 1'b1; resp_i8 = 1'b1; burst_i8 = '0;
      for (int c = 1; c <= 11; c++) begin
        tick();
        read_i8 = 1'b0;
        if (c == 1) begin
          n_tests++;
          if (address_o8 !== 32'h0000_0040) begin n_fail++; $display("FAIL b8_addr%0d: got %h want 00000040", r, address_o8); end
        end
        if (read_o8) rd_cnt++;
        if (resp_o8 && resp_cyc == 0) resp_cyc = c;
        burst_i8 = (c <= 8) ? 32'h80 + 32'(r * 16) + 32'(c - 1) : 32'h0;
      end
      n_tests++; if (rd_cnt !== 8)   begin n_fail++; $display("FAIL b8_beats%0d: got %0d want 8", r, rd_cnt); end
      n_tests++; if (resp_cyc !== 9) begin n_fail++; $display("FAIL b8_resp%0d: got %0d want 9", r, resp_cyc); end
      n_tests++; if (line_o8 !== exp_line) begin n_fail++; $display("FAIL b8_line%0d: got %h want %h", r, line_o8, exp_line); end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp_line;
    int rd_cnt, resp_cnt;
    for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = 64'hF0 + 64'(k);
    rd_cnt = 0; resp_cnt = 0;
    address_i = 32'h0000_0300; read_i = 1'b1; resp_i = 1'b1; burst_i = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 6) read_i = 1'b0;
      if (read_o) rd_cnt++;
      if (resp_o) resp_cnt++;
      burst_i = (c <= 4) ? 64'hF0 + 64'(c - 1) : 64'h55;
    end
    n_tests++; if (rd_cnt !== 4)   begin n_fail++; $display("FAIL hold_read_beats: got %0d want 4", rd_cnt); end
    n_tests++; if (resp_cnt !== 1) begin n_fail++; $display("FAIL hold_resp_count: got %0d want 1", resp_cnt); end
    n_tests++; if (line_o !== exp_line) begin n_fail++; $display("FAIL hold_line: got %h want %h", line_o, exp_line); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0;
    line_i = '0; address_i = '0; wb_address_i = '0; read_i = 1'b0; write_i = 1'b0;
    resp_i = 1'b0; burst_i = '0;
    line_i8 = '0; address_i8 = '0; wb_address_i8 = '0; read_i8 = 1'b0; write_i8 = 1'b0;
    resp_i8 = 1'b0; burst_i8 = '0;
    repeat (3) tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_read();
    test_write_stall();
    test_combined();
    test_reset_mid_fill();
    test_beats8();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
